// File: rtl/memory_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request passes IDLE -> WAIT (WAIT_CYCLES cycles) -> ACCESS -> RESP.
// Only one request is ever outstanding.
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The counter is loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        bad;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Misaligned or beyond the last word: flagged, no memory effect, data 0.
  assign bad = (addr_q[1:0] != 2'b00) ||
               ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign idx = addr_q[AW+1:2];

  // Handshake outputs come straight from the state register.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Control FSM, request latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ACCESS: begin
          state     <= RESP;
          rsp_err   <= bad;
          rsp_rdata <= (write_q || bad) ? 32'd0 : mem[idx];
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-enabled store commit; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && write_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: instance 1 uses WAIT_CYCLES=2, instance 0 uses WAIT_CYCLES=0.
// Expected responses are queued when a request is issued and compared on rsp_valid.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_acc [2];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge with the DUT idle; returns at the negedge
  // after the response handshake. hold = cycles rsp_ready is held low in RESP.
  task automatic do_req(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] er, input logic ee, input int hold);
    int   n;
    int   acc;
    exp_t e;
    sb.push_back('{rdata: er, err: ee});
    rsp_ready[d] = (hold == 0);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    acc = cyc + 1;
    last_acc[d] = acc;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h5555_5555;
    n = 0;
    while (!rsp_valid[d] && n < 50) begin @(negedge clk); n++; end
    chk("rsp_timeout", 32'(n < 50), 32'd1);
    // rsp_valid rises on the (WAIT_CYCLES+1)th edge after the acceptance edge,
    // i.e. WAIT_CYCLES+2 cycles counting the acceptance cycle itself.
    chk("rsp_latency", 32'(cyc - acc), (d == 0) ? 32'd1 : 32'd3);
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata[d], e.rdata);
    chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      // A competing request while the response is pending must be ignored.
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h0BAD_0BAD;
      req_be[d]    = 4'hF;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], e.rdata);
      chk("hold_err", 32'(rsp_err[d]), 32'(e.err));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    chk("post_hs_ready", 32'(req_ready[d]), 32'd1);
    chk("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic chk_reset_state(input int d);
    chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b1;
      last_acc[d] = 0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    chk_reset_state(0);
    chk_reset_state(1);

    // WAIT_CYCLES=2: full store then load
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);
    // partial store, load with be=0 still returns the whole word
    do_req(1, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
    do_req(1, 1'b1, 32'h10, 32'h77665544, 4'b0100, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE66BEAA, 1'b0, 0);
    // error cases leave memory alone (0x1000 would alias word 0 if unchecked)
    do_req(1, 1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    do_req(1, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1, 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE66BEAA, 1'b0, 0);
    do_req(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    do_req(1, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 0);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'hF, 32'h11223344, 1'b0, 0);
    // last legal word
    do_req(1, 1'b1, 32'hFFC, 32'hA5A5C3C3, 4'hF, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'hFFC, 32'h0, 4'hF, 32'hA5A5C3C3, 1'b0, 0);
    // be=0 store writes nothing, no error
    do_req(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    // backpressure for 5 cycles with competing requests
    do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE66BEAA, 1'b0, 5);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE66BEAA, 1'b0, 0);

    // reset caught in WAIT cancels the store
    do_req(1, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h12345678; req_be[1] = 4'hF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("accepted_before_reset", 32'(req_ready[1]), 32'd0);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk_reset_state(1);
    repeat (4) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_valid[1]), 32'd0);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);

    // WAIT_CYCLES=0: back-to-back loads, one acceptance every 3 cycles
    do_req(0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      int prev;
      prev = last_acc[0];
      do_req(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 0);
      chk("accept_spacing", 32'(last_acc[0] - prev), 32'd3);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access; legal range 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents a request.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement states IDLE, WAIT, ACCESS, RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE, decoded from registered state only, with no combinational path from any input.
REQ-017 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, latching write, addr, wdata and be.
REQ-018 SHALL move IDLE->WAIT on acceptance when WAIT_CYCLES>0, and IDLE->ACCESS when WAIT_CYCLES=0.
REQ-019 SHALL remain in WAIT for exactly WAIT_CYCLES cycles using a 4-bit down-counter, then move to ACCESS.
REQ-020 SHALL spend exactly one cycle in ACCESS, then move to RESP.
REQ-021 SHALL drive rsp_valid high in RESP, with rsp_valid first high WAIT_CYCLES+2 cycles after the acceptance edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then move to IDLE.
REQ-023 SHALL ignore req_valid in every state except IDLE.
REQ-024 SHALL set rsp_err=1 when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; memory SHALL NOT change and rsp_rdata SHALL be 0.
REQ-025 SHALL commit a store on the ACCESS edge, writing only the enabled bytes; be=0 SHALL write nothing and return rsp_err=0.
REQ-026 SHALL register load data from word addr[31:2] on the ACCESS edge, returning the full 32-bit word regardless of be.
REQ-027 SHALL return stored data to a load issued immediately after a store to the same word.
REQ-028 SHALL re-assert req_ready the cycle after the response handshake, giving at most one outstanding request.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the wait counter at 0.
REQ-030 SHALL let reset take priority over every transition; a store caught by reset in WAIT SHALL NOT be committed.
REQ-031 SHALL leave memory contents unchanged on reset; storage is not initialised.

Verification
REQ-032 SHALL pass this case with WAIT_CYCLES=2: store 0xDEADBEEF, be=4'hF at addr 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 4 cycles after each acceptance.
REQ-033 SHALL pass this case: word 0x10 = 0xDEADBEEF, store 0x000000AA with be=4'b0001 -> load 0x10 returns 0xDEADBEAA.
REQ-034 SHALL pass this case: load 0x13, and separately store to 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, rsp_rdata=0, target word unchanged.
REQ-035 SHALL pass this case: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata/err stable, req_ready=0 throughout, new req_valid ignored.
REQ-036 SHALL pass this case: reset during WAIT of a store 0x12345678 to 0x20 with old contents 0x0 -> IDLE next cycle, later load of 0x20 returns 0x0.
REQ-037 SHALL pass this case with WAIT_CYCLES=0: back-to-back loads with rsp_ready=1 -> rsp_valid 2 cycles after acceptance, one request accepted every 3 cycles.
